// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for an N x N systolic PE array.
// Issues K operand reads to the A/B RAMs, skews the edge valids across the
// array, holds pe_en over the compute wavefront, then drains one result row
// per handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start with a non-zero k_len
// LOAD   | k_len cycles of A/B reads at base + c
// FLUSH  | RAM_LAT + 2N - 1 cycles for latency, skew and product register
// DRAIN  | present drain_row, advance on drain_vld & drain_rdy
// DONE   | one-cycle done pulse
module pe_array_ctrl #(
  parameter int N       = 4,
  parameter int K_W     = 8,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1,
  parameter int ROW_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  output logic [N-1:0]      row_vld,
  output logic [N-1:0]      col_vld,
  output logic              pe_en,
  output logic              acc_clr,
  output logic              drain_vld,
  output logic [ROW_W-1:0]  drain_row,
  input  logic              drain_rdy
);

  localparam int FLUSH_CYC = RAM_LAT + 2 * N - 1;
  localparam int FL_W      = $clog2(FLUSH_CYC + 1);
  localparam int DLY_W     = RAM_LAT + N - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [K_W-1:0]    k_q;
  logic [K_W-1:0]    ld_cnt;
  logic [ADDR_W-1:0] a_q, b_q;
  logic [FL_W-1:0]   fl_cnt;
  logic [ROW_W-1:0]  row_q;
  logic [DLY_W-1:0]  dly;
  logic              accept, abort_job, ld_last, fl_last, row_last, rd_en;

  assign accept    = (state == S_IDLE) && start && (k_len != '0);
  assign abort_job = abort && (state != S_IDLE);
  assign ld_last   = (ld_cnt == k_q - K_W'(1));
  assign fl_last   = (fl_cnt == '0);
  assign row_last  = (row_q == ROW_W'(N - 1));
  assign rd_en     = (state == S_LOAD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state outputs; abort overrides every transition
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    a_rd_en   = 1'b0;
    b_rd_en   = 1'b0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    pe_en     = 1'b0;
    acc_clr   = 1'b0;
    drain_vld = 1'b0;
    drain_row = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        pe_en     = 1'b1;
        a_rd_en   = 1'b1;
        b_rd_en   = 1'b1;
        a_rd_addr = a_q + ADDR_W'(ld_cnt);
        b_rd_addr = b_q + ADDR_W'(ld_cnt);
        acc_clr   = (ld_cnt == '0);
        if (ld_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy  = 1'b1;
        pe_en = 1'b1;
        if (fl_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        drain_vld = 1'b1;
        drain_row = row_q;
        if (drain_rdy && row_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_job) state_nxt = S_IDLE;
  end

  // Job parameters latch on accept; LOAD counts up for addressing, FLUSH counts down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ld_cnt <= '0;
      fl_cnt <= '0;
      row_q  <= '0;
    end else if (accept) begin
      k_q    <= k_len;
      a_q    <= a_base;
      b_q    <= b_base;
      ld_cnt <= '0;
      fl_cnt <= FL_W'(FLUSH_CYC - 1);
      row_q  <= '0;
    end else begin
      if (state == S_LOAD && !ld_last)
        ld_cnt <= ld_cnt + K_W'(1);
      if (state == S_FLUSH && !fl_last)
        fl_cnt <= fl_cnt - FL_W'(1);
      if (state == S_DRAIN && drain_rdy && !row_last)
        row_q <= row_q + ROW_W'(1);
    end
  end

  // Shared skew line: A and B reads are issued together, so one line serves both edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dly <= '0;
    else if (abort_job) dly <= '0;
    else                dly <= {dly[DLY_W-2:0], rd_en};
  end

  // Tap RAM_LAT + i of the read enable feeds row i and column i
  always_comb begin
    row_vld = '0;
    col_vld = '0;
    for (int i = 0; i < N; i++) begin
      row_vld[i] = dly[RAM_LAT + i - 1];
      col_vld[i] = dly[RAM_LAT + i - 1];
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: each accepted job is queued with its
// LOAD start cycle; the monitor derives every expected output from the
// job's cycle offset and pops the job on done or abort.
module tb_pe_array_ctrl;
  localparam int N = 4, K_W = 8, ADDR_W = 8, RAM_LAT = 1, ROW_W = 2;
  localparam int F = RAM_LAT + 2 * N - 1;
  localparam int AMOD = 1 << ADDR_W;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, drain_rdy = 1'b1;
  logic [K_W-1:0]    k_len = '0;
  logic [ADDR_W-1:0] a_base = '0, b_base = '0;
  logic              busy, done, a_rd_en, b_rd_en, pe_en, acc_clr, drain_vld;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [N-1:0]      row_vld, col_vld;
  logic [ROW_W-1:0]  drain_row;

  pe_array_ctrl #(.N(N), .K_W(K_W), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .a_base(a_base),
    .b_base(b_base), .abort(abort), .busy(busy), .done(done), .a_rd_en(a_rd_en),
    .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .row_vld(row_vld), .col_vld(col_vld), .pe_en(pe_en), .acc_clr(acc_clr),
    .drain_vld(drain_vld), .drain_row(drain_row), .drain_rdy(drain_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {int t0; int k; int a; int b; int acc;} job_t;
  job_t jobs[$];

  int checks = 0, failures = 0, last_done = -1;
  int rdy_mode = 0, hold_lo = -1, hold_hi = -1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_a_en"}, int'(a_rd_en), 0);
    chk({tag, "_a_addr"}, int'(a_rd_addr), 0);
    chk({tag, "_b_en"}, int'(b_rd_en), 0);
    chk({tag, "_b_addr"}, int'(b_rd_addr), 0);
    chk({tag, "_row_vld"}, int'(row_vld), 0);
    chk({tag, "_col_vld"}, int'(col_vld), 0);
    chk({tag, "_pe_en"}, int'(pe_en), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_drain_vld"}, int'(drain_vld), 0);
    chk({tag, "_drain_row"}, int'(drain_row), 0);
  endtask

  // Monitor: expected outputs from the front job's offset into its timeline
  task automatic mon();
    int off, k, acc, ea, eb;
    bit act, ld, fl, dr, dn;
    logic [N-1:0] ev;
    act = (jobs.size() != 0) && (cyc >= jobs[0].t0);
    ld = 0; fl = 0; dr = 0; dn = 0; ev = '0; ea = 0; eb = 0; off = 0; k = 0; acc = 0;
    if (act) begin
      off = cyc - jobs[0].t0;
      k   = jobs[0].k;
      acc = jobs[0].acc;
      ld  = off < k;
      fl  = (off >= k) && (off < k + F);
      dr  = (off >= k + F) && (acc < N);
      dn  = (acc == N);
      for (int i = 0; i < N; i++)
        ev[i] = (off >= RAM_LAT + i) && (off < RAM_LAT + i + k);
      if (ld) begin
        ea = (jobs[0].a + off) % AMOD;
        eb = (jobs[0].b + off) % AMOD;
      end
    end
    chk("busy", int'(busy), int'(act));
    chk("done", int'(done), int'(dn));
    chk("a_rd_en", int'(a_rd_en), int'(ld));
    chk("b_rd_en", int'(b_rd_en), int'(ld));
    chk("a_rd_addr", int'(a_rd_addr), ea);
    chk("b_rd_addr", int'(b_rd_addr), eb);
    chk("acc_clr", int'(acc_clr), int'(ld && off == 0));
    chk("pe_en", int'(pe_en), int'(ld || fl));
    chk("row_vld", int'(row_vld), int'(ev));
    chk("col_vld", int'(col_vld), int'(ev));
    chk("drain_vld", int'(drain_vld), int'(dr));
    chk("drain_row", int'(drain_row), dr ? acc : 0);
    if (act) begin
      if (abort) void'(jobs.pop_front());
      else if (dn) begin
        last_done = cyc;
        void'(jobs.pop_front());
      end else if (dr && drain_rdy) jobs[0].acc = jobs[0].acc + 1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon();
  end

  // Consumer ready: always, random, or low over a cycle window
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       drain_rdy = 1'b1;
      1:       drain_rdy = 1'($urandom);
      default: drain_rdy = !(cyc >= hold_lo && cyc <= hold_hi);
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1 of the start cycle; returns once the job has left the scoreboard
  task automatic run_job(input int k, input int a, input int b, input int abort_off,
                         input bit mid_start, input int rst_off, output int t0);
    int n, off;
    job_t j;
    k_len  = K_W'(k);
    a_base = ADDR_W'(a);
    b_base = ADDR_W'(b);
    start  = 1'b1;
    abort  = (abort_off == -1);
    t0     = cyc + 1;
    if (k != 0) begin
      j.t0 = t0; j.k = k; j.a = a; j.b = b; j.acc = 0;
      jobs.push_back(j);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    a_base = ADDR_W'($urandom);
    b_base = ADDR_W'($urandom);
    k_len  = K_W'($urandom);
    n = 0;
    while (jobs.size() != 0 && n < 4000) begin
      off   = cyc - t0;
      abort = (off == abort_off);
      start = mid_start && (off == 1);
      if (start) k_len = K_W'($urandom_range(1, 255));
      if (off == rst_off) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("arst");
        jobs.delete();
      end
      @(posedge clk);
      #1;
      n++;
    end
    abort = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    if (jobs.size() != 0) begin
      failures++;
      $display("FAIL job_timeout cyc=%0d actual=pending required=complete", cyc);
      jobs.delete();
    end
  endtask

  initial begin
    int t0, k, ab;
    #3 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    run_job(3, 'h10, 'h20, -100, 0, -100, t0);
    chk("basic_done_cycle", last_done, t0 + 15);
    idle(1);

    rdy_mode = 2; hold_lo = cyc + 1 + 11; hold_hi = cyc + 1 + 13;
    run_job(3, 'h10, 'h20, -100, 0, -100, t0);
    chk("bp_done_cycle", last_done, t0 + 18);
    rdy_mode = 0;

    run_job(0, 'h33, 'h44, -100, 0, -100, t0);
    idle(4);

    run_job(3, 'h10, 'h20, -100, 1, -100, t0);
    chk("overlap_done_cycle", last_done, t0 + 15);

    run_job(8, 'h40, 'h80, 4, 0, -100, t0);
    idle(20);

    run_job(2, 'h05, 'h06, -1, 0, -100, t0);
    chk("abort_start_done_cycle", last_done, t0 + 2 + F + N);

    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(2);

    run_job(4, 'hFE, 'hFD, -100, 0, -100, t0);
    run_job(255, 'h80, 'h01, -100, 0, -100, t0);
    chk("max_done_cycle", last_done, t0 + 255 + F + N);

    run_job(5, 'h11, 'h22, -100, 0, 7, t0);
    run_job(1, 'h01, 'h02, -100, 0, -100, t0);
    chk("post_reset_done_cycle", last_done, t0 + 13);

    rdy_mode = 1;
    for (int r = 0; r < 25; r++) begin
      k  = int'($urandom_range(1, 20));
      ab = ($urandom % 4 == 0) ? int'($urandom_range(0, k + F + 6)) : -100;
      run_job(k, int'($urandom % 256), int'($urandom % 256), ab, 1'($urandom), -100, t0);
    end
    rdy_mode = 0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
